// File: rtl/seq_issue_ctrl.sv
// Issue/commit sequencer: owns PC, instruction fetch and the 32x32 register file,
// stepping each instruction through FETCH/DECODE/EXEC/WB for the execute stage.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | parked, waiting for run; ins driven as bubble
// FETCH  | imem_addr presented, ROM read in flight
// DECODE | imem_data valid; latch ins and source registers
// EXEC   | execute stage works on ins/pc/reg1/reg2, data memory captures
// WB     | commit result/nextpc, count retirement, sample run
module seq_issue_ctrl #(
  parameter int unsigned IMEM_AW  = 8,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic               clk,
  input  logic               rstd,
  input  logic               run,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        ins,
  output logic [31:0]        pc,
  output logic [31:0]        reg1,
  output logic [31:0]        reg2,
  input  logic [4:0]         wra,
  input  logic [31:0]        result,
  input  logic [31:0]        nextpc,
  input  logic [4:0]         dbg_ra,
  output logic [31:0]        dbg_rd,
  output logic [31:0]        retired,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  state_t      state;
  logic [31:0] rf [0:31];

  function automatic logic [31:0] rf_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf[a];
  endfunction

  assign imem_addr = pc[IMEM_AW-1:0];
  assign dbg_rd    = rf_rd(dbg_ra);
  assign busy      = (state != S_IDLE);

  // ins doubles as the held instruction: loaded at DECODE, cleared on commit,
  // so it reads as a bubble everywhere except EXEC and WB.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      ins     <= '0;
      reg1    <= '0;
      reg2    <= '0;
      retired <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) state <= S_FETCH;
        end
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          ins   <= imem_data;
          reg1  <= rf_rd(imem_data[25:21]);
          reg2  <= rf_rd(imem_data[20:16]);
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_WB;
        end
        S_WB: begin
          if (wra != 5'd0) rf[wra] <= result;
          pc      <= nextpc;
          retired <= retired + 32'd1;
          ins     <= '0;
          state   <= run ? S_FETCH : S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
